// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - state, select and sizing constants shared by the bus arbiter
package arb_pkg;

   localparam int unsigned NUM_REQ = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_e;

   localparam logic [1:0] SEL_D1 = 2'b00;
   localparam logic [1:0] SEL_D2 = 2'b01;
   localparam logic [1:0] SEL_D3 = 2'b10;

   // Round-robin successor; indices wrap 2 -> 0.
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   function automatic logic [1:0] sel_of(input logic [1:0] idx);
      case (idx)
         2'd1:    return SEL_D2;
         2'd2:    return SEL_D3;
         default: return SEL_D1;
      endcase
   endfunction

endpackage

// File: rtl/mux_bus_arbiter_if.sv
// rtl/mux_bus_arbiter_if.sv - request/grant/select bundle between requesters and the arbiter
interface mux_bus_arbiter_if;
   logic [2:0] req;
   logic [2:0] gnt;
   logic       sel1;
   logic       sel2;
   logic       bus_valid;
   logic [1:0] owner;
   logic       timeout;

   modport master (
      input  req,
      output gnt, sel1, sel2, bus_valid, owner, timeout
   );

   modport slave (
      output req,
      input  gnt, sel1, sel2, bus_valid, owner, timeout
   );
endinterface

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - three-way round-robin winner search starting after the last owner
module rr_pick3
   import arb_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic [1:0] win,
   output logic       any
);

   logic [1:0] cand;
   logic       found;

   assign any = |req;

   always_comb begin
      win   = 2'd0;
      cand  = last;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = rr_next(cand);
         if (req[cand] && !found) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_bus_arbiter.sv
// rtl/mux_bus_arbiter.sv - round-robin owner of the 3-input bus mux; hold limit under ARB_TIMEOUT_EN
module mux_bus_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic               clk,
   input  logic               rst,
   mux_bus_arbiter_if.master  arb_if
);

   arb_state_e state_q, state_d;
   logic [1:0] last_q, last_d;
   logic [1:0] owner_q, owner_d;
   logic [2:0] gnt_q, gnt_d;
   logic [1:0] sel_q, sel_d;
   logic       valid_q, valid_d;
   logic       timeout_q, timeout_d;
   logic [1:0] win;
   logic       any;
   logic       hold_hit;

   rr_pick3 u_pick (
      .req  (arb_if.req),
      .last (last_q),
      .win  (win),
      .any  (any)
   );

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign hold_hit = (cnt_q == CNT_W'(MAX_HOLD - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   logic unused_cfg;

   assign hold_hit   = 1'b0;
   assign unused_cfg = (2 ** CNT_W > MAX_HOLD);
`endif

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      owner_d   = owner_q;
      gnt_d     = '0;
      sel_d     = SEL_D1;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         GRANT: begin
            if (!arb_if.req[owner_q]) begin
               state_d = TURN;
            end else if (hold_hit) begin
               state_d   = TURN;
               timeout_d = 1'b1;
            end else begin
               gnt_d   = gnt_q;
               sel_d   = sel_q;
               valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = cnt_q + CNT_W'(1);
`endif
            end
         end
         // IDLE and TURN both arbitrate; TURN has already forced the dead cycle.
         default: begin
            if (any) begin
               state_d = GRANT;
               owner_d = win;
               last_d  = win;
               gnt_d   = 3'b001 << win;
               sel_d   = sel_of(win);
               valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         last_q    <= 2'd2;
         owner_q   <= 2'd0;
         gnt_q     <= '0;
         sel_q     <= SEL_D1;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         owner_q   <= owner_d;
         gnt_q     <= gnt_d;
         sel_q     <= sel_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign arb_if.gnt       = gnt_q;
   assign arb_if.sel1      = sel_q[1];
   assign arb_if.sel2      = sel_q[0];
   assign arb_if.bus_valid = valid_q;
   assign arb_if.owner     = owner_q;
   assign arb_if.timeout   = timeout_q;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// tb/tb_mux_bus_arbiter.sv - directed scoreboard bench for mux_bus_arbiter
module tb_mux_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned TB_MAX_HOLD = 4;
   localparam int unsigned TB_CNT_W    = 3;
`else
   localparam int unsigned TB_MAX_HOLD = 16;
   localparam int unsigned TB_CNT_W    = 5;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      string      tag;
      logic [2:0] gnt;
      logic [1:0] sel;
      logic       valid;
      logic [1:0] owner;
      logic       tmo;
   } exp_t;

   exp_t sb[$];

   mux_bus_arbiter_if bus ();

   mux_bus_arbiter #(
      .MAX_HOLD (TB_MAX_HOLD),
      .CNT_W    (TB_CNT_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .arb_if (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive req for one cycle and check the registered outputs after the edge.
   task automatic step(input string tag, input logic [2:0] r, input logic [2:0] g,
                       input logic [1:0] o, input logic t);
      exp_t e;
      exp_t got;
      e.tag   = tag;
      e.gnt   = g;
      e.sel   = g[2] ? 2'b10 : (g[1] ? 2'b01 : 2'b00);
      e.valid = |g;
      e.owner = o;
      e.tmo   = t;
      bus.req = r;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk({got.tag, ".gnt"},   {5'd0, bus.gnt},             {5'd0, got.gnt});
      chk({got.tag, ".sel"},   {6'd0, bus.sel1, bus.sel2},  {6'd0, got.sel});
      chk({got.tag, ".valid"}, {7'd0, bus.bus_valid},       {7'd0, got.valid});
      chk({got.tag, ".owner"}, {6'd0, bus.owner},           {6'd0, got.owner});
      chk({got.tag, ".tmo"},   {7'd0, bus.timeout},         {7'd0, got.tmo});
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      bus.req = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.gnt",   {5'd0, bus.gnt},            8'h00);
      chk("rst.sel",   {6'd0, bus.sel1, bus.sel2}, 8'h00);
      chk("rst.valid", {7'd0, bus.bus_valid},      8'h00);
      chk("rst.owner", {6'd0, bus.owner},          8'h00);
      chk("rst.tmo",   {7'd0, bus.timeout},        8'h00);
      rst = 1'b0;

      step("idle_noreq", 3'b000, 3'b000, 2'd0, 1'b0);
      step("t1_grant0",  3'b001, 3'b001, 2'd0, 1'b0);
      step("t1_turn",    3'b000, 3'b000, 2'd0, 1'b0);
      step("t1_idle",    3'b000, 3'b000, 2'd0, 1'b0);

      pulse_reset();
      step("rr_g0",   3'b111, 3'b001, 2'd0, 1'b0);
      step("rr_t0",   3'b110, 3'b000, 2'd0, 1'b0);
      step("rr_g1",   3'b111, 3'b010, 2'd1, 1'b0);
      step("rr_t1",   3'b101, 3'b000, 2'd1, 1'b0);
      step("rr_g2",   3'b111, 3'b100, 2'd2, 1'b0);
      step("rr_t2",   3'b011, 3'b000, 2'd2, 1'b0);
      step("rr_g0b",  3'b111, 3'b001, 2'd0, 1'b0);
      step("rr_turn", 3'b000, 3'b000, 2'd0, 1'b0);
      step("rr_idle", 3'b000, 3'b000, 2'd0, 1'b0);

      step("sw_g1",   3'b010, 3'b010, 2'd1, 1'b0);
      step("sw_hold", 3'b010, 3'b010, 2'd1, 1'b0);
      step("sw_turn", 3'b100, 3'b000, 2'd1, 1'b0);
      step("sw_g2",   3'b100, 3'b100, 2'd2, 1'b0);

      // Owner 2 is granted now; reset must clear outputs without a clock edge.
      rst = 1'b1;
      #1;
      chk("async.gnt",   {5'd0, bus.gnt},            8'h00);
      chk("async.sel",   {6'd0, bus.sel1, bus.sel2}, 8'h00);
      chk("async.valid", {7'd0, bus.bus_valid},      8'h00);
      chk("async.owner", {6'd0, bus.owner},          8'h00);
      #1;
      rst = 1'b0;
      step("post_rst_g1", 3'b110, 3'b010, 2'd1, 1'b0);
      step("nolatch_hold", 3'b011, 3'b010, 2'd1, 1'b0);
      step("nolatch_turn", 3'b000, 3'b000, 2'd1, 1'b0);
      step("nolatch_idle", 3'b000, 3'b000, 2'd1, 1'b0);

`ifdef ARB_TIMEOUT_EN
      pulse_reset();
      for (int i = 0; i < 4; i++) step("to_hold", 3'b011, 3'b001, 2'd0, 1'b0);
      step("to_revoke", 3'b011, 3'b000, 2'd0, 1'b1);
      step("to_next",   3'b011, 3'b010, 2'd1, 1'b0);
      step("to_drop",   3'b000, 3'b000, 2'd1, 1'b0);
`else
      for (int i = 0; i < 100; i++) step("long_hold", 3'b001, 3'b001, 2'd0, 1'b0);
      step("long_drop", 3'b000, 3'b000, 2'd0, 1'b0);
`endif

      chk("sb_drained", 8'(sb.size()), 8'h00);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
